// File: rtl/codes_ex_top.sv
// Hamming(7,4) codec demonstrator: registered encoder, constant error-injection
// mask, and a registered syndrome decoder that corrects any single-bit error.
module codes_ex_top #(
  parameter logic [6:0] ERR_MASK = 7'b0000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  output logic [6:0] code_out,
  output logic [2:0] syndrome,
  output logic [3:0] data_out
);

  logic [6:0] r_code;
  logic [2:0] r_syn;
  logic [3:0] r_data;

  logic [6:0] w_enc;
  logic [6:0] w_recv;
  logic [2:0] w_syn;
  logic [6:0] w_flip;
  logic [6:0] w_corr;

  // Even-parity encoder; codeword bit k-1 holds Hamming position k.
  always_comb begin
    w_enc[0] = data_in[0] ^ data_in[1] ^ data_in[3];
    w_enc[1] = data_in[0] ^ data_in[2] ^ data_in[3];
    w_enc[2] = data_in[0];
    w_enc[3] = data_in[1] ^ data_in[2] ^ data_in[3];
    w_enc[4] = data_in[1];
    w_enc[5] = data_in[2];
    w_enc[6] = data_in[3];
  end

  assign w_recv = r_code ^ ERR_MASK;

  // The syndrome spells out the 1-based position of a single flipped bit.
  always_comb begin
    w_syn[0] = w_recv[0] ^ w_recv[2] ^ w_recv[4] ^ w_recv[6];
    w_syn[1] = w_recv[1] ^ w_recv[2] ^ w_recv[5] ^ w_recv[6];
    w_syn[2] = w_recv[3] ^ w_recv[4] ^ w_recv[5] ^ w_recv[6];
  end

  always_comb begin
    w_flip = 7'd0;
    if (w_syn != 3'd0) begin
      w_flip = 7'd1 << (w_syn - 3'd1);
    end
  end

  assign w_corr = w_recv ^ w_flip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code <= 7'h00;
      r_syn  <= 3'b000;
      r_data <= 4'h0;
    end else begin
      r_code <= w_enc;
      r_syn  <= w_syn;
      r_data <= {w_corr[6], w_corr[5], w_corr[4], w_corr[2]};
    end
  end

  assign code_out = r_code;
  assign syndrome = r_syn;
  assign data_out = r_data;

endmodule

// File: tb/tb_codes_ex_top.sv
// Self-checking bench for codes_ex_top: nine instances share one input stream,
// each with a different injected error pattern (none, each single bit, one double).
module tb_codes_ex_top;

   localparam int NDUT = 9;

   // Instance 0: clean channel; 1..7: flip position g; 8: flip positions 1 and 2.
   function automatic logic [6:0] maskOf(input int g);
      logic [6:0] m;
      m = 7'd0;
      if (g >= 1 && g <= 7) m[g-1] = 1'b1;
      if (g == 8) m = 7'b0000011;
      return m;
   endfunction

   logic       clk;
   logic       rst;
   logic [3:0] dataIn;
   logic [6:0] codeOut [NDUT];
   logic [2:0] synOut  [NDUT];
   logic [3:0] dataOut [NDUT];

   int testsRun;
   int testsFailed;

   logic [6:0] modelCode;
   logic [2:0] expSyn  [NDUT];
   logic [3:0] expData [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      codes_ex_top #(.ERR_MASK(maskOf(g))) dut (
         .clk      (clk),
         .rst      (rst),
         .data_in  (dataIn),
         .code_out (codeOut[g]),
         .syndrome (synOut[g]),
         .data_out (dataOut[g])
      );
   end

   // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference syndrome: XOR of the positions of every set bit.
   function automatic logic [2:0] refSyndrome(input logic [6:0] r);
      logic [2:0] s;
      s = 3'd0;
      for (int k = 1; k <= 7; k++) if (r[k-1]) s ^= 3'(k);
      return s;
   endfunction

   // Reference encoder: place data, then pick parity bits so the word's syndrome is zero.
   function automatic logic [6:0] refEncode(input logic [3:0] d);
      logic [6:0] c;
      logic [2:0] s;
      c = 7'd0;
      c[2] = d[0];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      s = refSyndrome(c);
      c[0] = s[0];
      c[1] = s[1];
      c[3] = s[2];
      return c;
   endfunction

   function automatic logic [3:0] refDecode(input logic [6:0] r);
      logic [6:0] c;
      logic [2:0] s;
      c = r;
      s = refSyndrome(r);
      if (s != 3'd0) c[s-1] = ~c[s-1];
      return {c[6], c[5], c[4], c[2]};
   endfunction

   task automatic checkOutput(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s[%0d]: got %0h, expected %0h", tag, g, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      for (int g = 0; g < NDUT; g++) begin
         checkOutput({tag, "_code"}, g, 32'(codeOut[g]), 32'h0);
         checkOutput({tag, "_syn"},  g, 32'(synOut[g]),  32'h0);
         checkOutput({tag, "_data"}, g, 32'(dataOut[g]), 32'h0);
      end
   endtask

   // One clock of stimulus: advance the model across the edge, then compare every instance.
   task automatic applyStimulus(input logic [3:0] d);
      dataIn = d;
      @(posedge clk);
      for (int g = 0; g < NDUT; g++) begin
         expSyn[g]  = refSyndrome(modelCode ^ maskOf(g));
         expData[g] = refDecode(modelCode ^ maskOf(g));
      end
      modelCode = refEncode(d);
      #1;
      for (int g = 0; g < NDUT; g++) begin
         checkOutput("code", g, 32'(codeOut[g]), 32'(modelCode));
         checkOutput("syn",  g, 32'(synOut[g]),  32'(expSyn[g]));
         checkOutput("data", g, 32'(dataOut[g]), 32'(expData[g]));
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      modelCode   = 7'd0;
      rst         = 1'b0;
      dataIn      = 4'hF;

      // Power-on reset, then release between edges.
      #1;
      checkAllZero("por");
      @(posedge clk);
      #1;
      checkAllZero("por_hold");
      #2 rst = 1'b1;

      // Directed encodes against hand-computed codewords.
      applyStimulus(4'h0);
      checkOutput("enc_0", 0, 32'(codeOut[0]), 32'h00);
      applyStimulus(4'h1);
      checkOutput("enc_1", 0, 32'(codeOut[0]), 32'h07);
      applyStimulus(4'hB);
      checkOutput("enc_B", 0, 32'(codeOut[0]), 32'h55);
      applyStimulus(4'hF);
      checkOutput("enc_F", 0, 32'(codeOut[0]), 32'h7F);
      // The 4'hB word is now decoded: each single-bit error must be located and corrected.
      for (int g = 1; g <= 7; g++) begin
         checkOutput("single_syn",  g, 32'(synOut[g]),  32'(g));
         checkOutput("single_data", g, 32'(dataOut[g]), 32'hB);
      end

      // Double error on an all-zero word lands on a known miscorrection.
      applyStimulus(4'h0);
      applyStimulus(4'h0);
      checkOutput("double_syn",  8, 32'(synOut[8]),  32'h3);
      checkOutput("double_data", 8, 32'(dataOut[8]), 32'h1);

      // Full sweep on every instance.
      for (int v = 0; v < 16; v++) begin
         applyStimulus(4'(v));
         checkOutput("sweep_syn0", 0, 32'(synOut[0]), 32'h0);
      end

      // Sweep again with an asynchronous reset pulse in the middle.
      for (int v = 0; v < 8; v++) applyStimulus(4'(v));
      #2;
      rst    = 1'b0;
      dataIn = 4'hF;
      #1;
      checkAllZero("midrst");
      @(posedge clk);
      #1;
      checkAllZero("midrst_hold");
      #2 rst = 1'b1;
      modelCode = 7'd0;
      for (int v = 8; v < 16; v++) applyStimulus(4'(v));

      // Randomized traffic against the reference model.
      for (int n = 0; n < 200; n++) applyStimulus(4'($urandom_range(0, 15)));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/codes_ex_top.md
# codes_ex_top

Hamming(7,4) single-error-correcting codec demonstrator. A 4-bit data word is encoded into a registered 7-bit codeword. The codeword passes through a parameterised error-injection mask and into a syndrome decoder, which registers the syndrome and the corrected 4-bit data. It is a self-contained top-level exercise block with no handshake; all paths are free-running pipeline stages.

## Interface
Parameters:
- ERR_MASK, 7'b0000000: constant XOR mask applied to the codeword between encoder and decoder. Bit k-1 flips Hamming position k. Zero means an error-free channel.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low: 0 = reset asserted, 1 = run.
- data_in  input  4  data word; d1=data_in[0], d2=[1], d3=[2], d4=[3].
- code_out  output  7  registered Hamming codeword; code_out[k-1] = position k.
- syndrome  output  3  registered syndrome {s4,s2,s1} of the received (masked) codeword.
- data_out  output  4  registered corrected data word, same bit order as data_in.

## Operation
- Codeword positions 1..7 are p1, p2, d1, p4, d2, d3, d4, so code_out = {d4,d3,d2,p4,d1,p2,p1}.
- Parity bits (even parity):
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Received word: r = code_out ^ ERR_MASK. This is combinational from the code_out register.
- Syndrome bits:
  - s1 = r1^r3^r5^r7
  - s2 = r2^r3^r6^r7
  - s4 = r4^r5^r6^r7
- Syndrome value S = {s4,s2,s1} is the 1-based position of the erroneous bit; S=0 means no error.
- Correction: if S≠0, invert bit position S of r; if S=0, pass r unchanged. data_out = {c7,c6,c5,c3} of the corrected word c.
- Any single-bit error is corrected.
- Double-bit errors produce a nonzero syndrome and a deterministic miscorrection; no detection flag is provided.
- Encoder and decoder are separate combinational functions; the only state is the code_out, syndrome and data_out registers.

## Timing
- Reset (rst=0, asynchronous): code_out=7'h00, syndrome=3'b000, data_out=4'h0 immediately, independent of clk. The registers hold these values while rst=0.
- Release: the first rising edge with rst=1 resumes normal updates. No synchronisation stage is required in this block.
- Latency:
  - data_in at edge N appears encoded on code_out after edge N.
  - The matching syndrome and data_out appear after edge N+1, i.e. data_out has 2 cycles of latency.
- Throughput: one new word per clock. data_in may change every cycle, and each word is processed independently in pipeline order.
- Reset mid-operation: in-flight words are discarded. After release, syndrome and data_out show stale zero-derived values for one cycle, then valid results.
- With ERR_MASK=0, syndrome is 0 on every cycle and data_out equals data_in delayed by 2 cycles.

## Test plan
- Reset: drive rst=0 asynchronously mid-cycle with data_in=4'hF -> all outputs go to 0 before the next edge and stay 0 while rst=0.
- Encode check, ERR_MASK=0 -> one cycle after each input is sampled, code_out must read:
  - data_in 4'h0 -> 7'h00
  - 4'h1 -> 7'h07
  - 4'hB -> 7'h55
  - 4'hF -> 7'h7F
- Sweep, ERR_MASK=0: apply data_in 0..15, one per cycle -> syndrome=0 throughout, and data_out equals data_in two cycles earlier for all 16 values.
- Single error, ERR_MASK=7'b0000100, data_in=4'hB -> received word 7'h51, syndrome=3'b011, data_out=4'hB. Repeat for each one-hot ERR_MASK k=1..7 -> syndrome=k, data_out correct.
- Double error, ERR_MASK=7'b0000011, data_in=4'h0 -> syndrome=3'b011, data_out=4'h1 (documented miscorrection).
- Reset mid-stream: apply a reset pulse during the sweep, then resume -> outputs are 0 during reset, and correct data_out resumes 2 cycles after the first post-release edge.
